// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder that routes one operand bit pair per clock through a
// single full_adder cell. A start request latches two WIDTH-bit operands and
// a carry-in. The operands are then shifted LSB-first through the cell, and
// the carry is fed back through a flop. Each sum bit enters a shift register
// from the top, so after WIDTH bits the register holds the sum in order.
//
// Handshake: start is a request that is accepted on any rising edge where
// busy is low, i.e. in IDLE or DONE. Starting from DONE gives back-to-back
// operation. A request made while busy is high is dropped, not queued.
// a, b and cin only matter on the accepting edge.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request; sampled only when not busy
//   a      in   [WIDTH-1:0] operand A, captured on accepted start
//   b      in   [WIDTH-1:0] operand B, captured on accepted start
//   cin    in   carry-in, captured on accepted start
//   busy   out  high while bits are being processed (state RUN)
//   done   out  one-cycle pulse: sum/cout valid and newly updated
//   sum    out  [WIDTH-1:0] registered result, held until next completion
//   cout   out  registered carry-out of the MSB, held with sum
// ---------------------------------------------------------------------------

// Single-bit full adder cell (a + b + c -> {co, s}).
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ c;
    assign co = (a & b) | (c & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic [WIDTH-1:0] s_next;
    logic             c_q;
    logic [CW-1:0]    cnt;

    logic fa_s;
    logic fa_co;
    logic accept;
    logic last_bit;

    full_adder u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .c  (c_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // The new sum bit enters at the MSB. With WIDTH=1 the register is only
    // the new bit, because the slice [WIDTH-1:1] would be empty.
    generate
        if (WIDTH == 1) begin : g_snext_w1
            assign s_next = fa_s;
        end else begin : g_snext_wn
            assign s_next = {fa_s, s_sh[WIDTH-1:1]};
        end
    endgenerate

    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign last_bit = (state == RUN) && (cnt == LAST);

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                if (cnt == LAST) state_next = DONE;
            end
            DONE: begin
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            s_sh <= '0;
            c_q  <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
        end else if (accept) begin
            a_sh <= a;
            b_sh <= b;
            c_q  <= cin;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            s_sh <= s_next;
            c_q  <= fa_co;
            cnt  <= cnt + CW'(1);
            // The outputs change only here, so they stay stable while the
            // next operation is running.
            if (last_bit) begin
                sum  <= s_next;
                cout <= fa_co;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//
// Directed testbench for serial_adder with WIDTH=8. Inputs are driven and
// outputs are sampled on the falling edge of clk.
// ---------------------------------------------------------------------------
module tb_serial_adder;
    localparam int W = 8;
    localparam int MAX_WAIT = 40;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_checks;
    int n_fail;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver: pulse start for one edge, then watch until done or timeout.
    // Returns with the bench at the falling edge where done was seen.
    task automatic drive_add(input logic [W-1:0] av, input logic [W-1:0] bv,
                             input logic ci, output int busy_cycles,
                             output int lat, output logic got_done);
        int i;
        @(negedge clk);
        a = av; b = bv; cin = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        busy_cycles = 0; lat = -1; got_done = 1'b0; i = 0;
        while (!got_done && i < MAX_WAIT) begin
            if (busy) busy_cycles++;
            if (done) begin
                got_done = 1'b1;
                lat = i;
            end else begin
                @(negedge clk);
                i++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, sum, cout} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b, want 0 0 00 0",
                     busy, done, sum, cout);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_release_idle: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_basic_add();
        int bc, lat;
        logic gd;
        drive_add(8'h5A, 8'h33, 1'b0, bc, lat, gd);
        n_checks++;
        if (gd !== 1'b1 || lat != 8) begin
            n_fail++;
            $display("FAIL basic_latency: got_done=%b latency=%0d, want 1 8", gd, lat);
        end
        n_checks++;
        if (bc != 8) begin
            n_fail++;
            $display("FAIL basic_busy_cycles: got %0d, want 8", bc);
        end
        n_checks++;
        if (sum !== 8'h8D || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_sum: sum=%h cout=%b, want 8d 0", sum, cout);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy_in_done: busy=%b, want 0", busy);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_one_cycle: done=%b, want 0", done);
        end
    endtask

    task automatic test_carry_out();
        int bc, lat;
        logic gd;
        drive_add(8'hFF, 8'h01, 1'b0, bc, lat, gd);
        n_checks++;
        if (gd !== 1'b1 || sum !== 8'h00 || cout !== 1'b1) begin
            n_fail++;
            $display("FAIL carry_ff_01: done=%b sum=%h cout=%b, want 1 00 1", gd, sum, cout);
        end
    endtask

    task automatic test_hold();
        int bc, lat;
        int bad;
        logic gd;
        drive_add(8'hFF, 8'hFF, 1'b1, bc, lat, gd);
        n_checks++;
        if (gd !== 1'b1 || sum !== 8'hFF || cout !== 1'b1) begin
            n_fail++;
            $display("FAIL carry_in_ff_ff_1: done=%b sum=%h cout=%b, want 1 ff 1", gd, sum, cout);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sum !== 8'hFF || cout !== 1'b1 || done !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_20_idle: %0d bad cycles (sum=%h cout=%b), want 0", bad, sum, cout);
        end
    endtask

    task automatic test_ignore_start();
        int n_done;
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0;
        n_done = 0;
        for (int i = 0; i < 25; i++) begin
            if (i == 3) begin
                a = 8'h01; b = 8'h01; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                n_done++;
                n_checks++;
                if (sum !== 8'h30 || cout !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ignore_start_sum: sum=%h cout=%b, want 30 0", sum, cout);
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        n_checks++;
        if (n_done != 1) begin
            n_fail++;
            $display("FAIL ignore_start_done_count: got %0d, want 1", n_done);
        end
    endtask

    task automatic test_back_to_back();
        int first_at, second_at, i;
        @(negedge clk);
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        first_at = -1; second_at = -1; i = 0;
        while (second_at < 0 && i < MAX_WAIT) begin
            if (i == 3) begin
                a = 8'h80; b = 8'h80;
            end
            if (done) begin
                if (first_at < 0) begin
                    first_at = i;
                    n_checks++;
                    if (sum !== 8'h03 || cout !== 1'b0) begin
                        n_fail++;
                        $display("FAIL b2b_first_sum: sum=%h cout=%b, want 03 0", sum, cout);
                    end
                end else begin
                    second_at = i;
                    start = 1'b0;
                    n_checks++;
                    if (sum !== 8'h00 || cout !== 1'b1) begin
                        n_fail++;
                        $display("FAIL b2b_second_sum: sum=%h cout=%b, want 00 1", sum, cout);
                    end
                end
            end
            if (second_at < 0) begin
                @(negedge clk);
                i++;
            end
        end
        start = 1'b0;
        n_checks++;
        if (first_at < 0 || second_at < 0 || (second_at - first_at) != 9) begin
            n_fail++;
            $display("FAIL b2b_spacing: first=%0d second=%0d, want spacing 9", first_at, second_at);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_back_to_idle: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_run();
        int n_done, bc, lat;
        logic gd;
        @(negedge clk);
        a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_run: busy=%b sum=%h cout=%b, want 0 00 0", busy, sum, cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        n_checks++;
        if (n_done != 0) begin
            n_fail++;
            $display("FAIL reset_no_done: got %0d done pulses, want 0", n_done);
        end
        drive_add(8'h0F, 8'h01, 1'b0, bc, lat, gd);
        n_checks++;
        if (gd !== 1'b1 || sum !== 8'h10 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset_add: done=%b sum=%h cout=%b, want 1 10 0", gd, sum, cout);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic_add();
        test_carry_out();
        test_hold();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
